// File: rtl/ahb_decode_ctrl.sv
// AHB address decoder, data-phase slave index register, default slave (two-cycle ERROR)
// and system HREADY/HRESP merge with a saturating default-slave error counter.
module ahb_decode_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] S1_BASE    = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] S1_MASK    = 32'hF000_0000,
  parameter logic [ADDR_WIDTH-1:0] S2_BASE    = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] S2_MASK    = 32'hF000_0000,
  parameter logic [ADDR_WIDTH-1:0] S3_BASE    = 32'h2000_0000,
  parameter logic [ADDR_WIDTH-1:0] S3_MASK    = 32'hF000_0000,
  parameter logic [ADDR_WIDTH-1:0] S4_BASE    = 32'h3000_0000,
  parameter logic [ADDR_WIDTH-1:0] S4_MASK    = 32'hF000_0000,
  parameter int                    CNT_WIDTH  = 8
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  mux_hreadyout,
  input  logic                  mux_hresp,
  output logic                  hsel_1,
  output logic                  hsel_2,
  output logic                  hsel_3,
  output logic                  hsel_4,
  output logic [1:0]            sel,
  output logic                  hready,
  output logic                  hresp,
  output logic                  def_active,
  output logic [CNT_WIDTH-1:0]  err_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [3:0]           hit_s;
  logic [1:0]           enc_s;
  logic                 unmapped_s;
  logic                 err_start_s;
  logic                 fsm_ready_s;
  logic                 fsm_resp_s;
  logic [1:0]           sel_r;
  logic                 def_active_r;
  logic [CNT_WIDTH-1:0] err_count_r;
  state_t               state_r;
  state_t               next_state_s;

  // Address decode with fixed priority 1>2>3>4 on overlapping regions
  always_comb begin
    hit_s[0] = ((haddr & S1_MASK) == S1_BASE);
    hit_s[1] = ((haddr & S2_MASK) == S2_BASE);
    hit_s[2] = ((haddr & S3_MASK) == S3_BASE);
    hit_s[3] = ((haddr & S4_MASK) == S4_BASE);
    hsel_1   = hit_s[0];
    hsel_2   = hit_s[1] & ~hit_s[0];
    hsel_3   = hit_s[2] & ~hit_s[1] & ~hit_s[0];
    hsel_4   = hit_s[3] & ~hit_s[2] & ~hit_s[1] & ~hit_s[0];
    unmapped_s = ~(|hit_s);
    if (hit_s[0]) begin
      enc_s = 2'd0;
    end else if (hit_s[1]) begin
      enc_s = 2'd1;
    end else if (hit_s[2]) begin
      enc_s = 2'd2;
    end else if (hit_s[3]) begin
      enc_s = 2'd3;
    end else begin
      enc_s = 2'd0;
    end
  end

  // Data-phase owner register, advances only when the bus is ready
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      sel_r        <= 2'd0;
      def_active_r <= 1'b0;
    end else if (hready) begin
      sel_r        <= enc_s;
      def_active_r <= unmapped_s;
    end
  end

  // Default-slave state register
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Default-slave next state; ERR2 is ready so it can accept another error back-to-back
  always_comb begin
    err_start_s  = hready & htrans[1] & unmapped_s;
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (err_start_s) begin
          next_state_s = ST_ERR1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ERR1: next_state_s = ST_ERR2;
      ST_ERR2: begin
        if (err_start_s) begin
          next_state_s = ST_ERR1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Default-slave response per state
  always_comb begin
    fsm_ready_s = 1'b1;
    fsm_resp_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        fsm_ready_s = 1'b1;
        fsm_resp_s  = 1'b0;
      end
      ST_ERR1: begin
        fsm_ready_s = 1'b0;
        fsm_resp_s  = 1'b1;
      end
      ST_ERR2: begin
        fsm_ready_s = 1'b1;
        fsm_resp_s  = 1'b1;
      end
      default: begin
        fsm_ready_s = 1'b1;
        fsm_resp_s  = 1'b0;
      end
    endcase
  end

  // Saturating count of completed default-slave ERROR responses
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      err_count_r <= {CNT_WIDTH{1'b0}};
    end else if ((state_r == ST_ERR1) && (err_count_r != CNT_MAX)) begin
      err_count_r <= err_count_r + CNT_ONE;
    end
  end

  // System response merge; reset forces a ready OKAY bus
  always_comb begin
    if (hreset) begin
      hready = 1'b1;
      hresp  = 1'b0;
    end else if (def_active_r) begin
      hready = fsm_ready_s;
      hresp  = fsm_resp_s;
    end else begin
      hready = mux_hreadyout;
      hresp  = mux_hresp;
    end
  end

  assign sel        = sel_r;
  assign def_active = def_active_r;
  assign err_count  = err_count_r;

endmodule
